// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and width helpers for the hazard scoreboard.
//            entry_t is the per-stage tracking record; the helper functions
//            derive the register-address width (RW) and forward-select
//            width (SW) from the pipeline parameters.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Widest register address an entry can hold (up to 256 registers).
  // Narrower RW values are zero-extended into this field.
  localparam int unsigned MAX_RW = 8;

  typedef struct packed {
    logic              valid;
    logic [MAX_RW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } entry_t;

  // RW = clog2(NREG), kept at least 1 so a degenerate register file still
  // yields a legal vector width.
  function automatic int unsigned reg_addr_width(input int unsigned nreg);
    return (nreg <= 1) ? 1 : $clog2(nreg);
  endfunction

  // SW = clog2(NSTAGE+1): encodes 0 (register file) plus one code per entry.
  function automatic int unsigned fwd_sel_width(input int unsigned nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_match
// Purpose  : Priority match of one source operand against the tracked
//            pipeline entries. The youngest (lowest index) valid writer of
//            the source register wins.
// Ports    : rs      - source register address
//            rs_used - source operand is actually read
//            ents    - tracked entries, index 0 = EX (youngest)
//            sel     - 0 = register file, j = result of entry j-1
//            hazard  - matching entry is a load that cannot forward yet
// Revision : 1.0 - initial release
// ============================================================================
module fwd_match
  import riscv_pkg::*;
#(
  parameter int NSTAGE   = 3,
  parameter int RW       = 5,
  parameter int SW       = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic [RW-1:0] rs,
  input  logic          rs_used,
  input  entry_t        ents [NSTAGE],
  output logic [SW-1:0] sel,
  output logic          hazard
);

  // Scan oldest to youngest so the last hit, i.e. the lowest index, wins.
  // Register 0 is hard-wired; it never matches, so it never forwards or stalls.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    if (rs_used && (rs != '0)) begin
      for (int i = NSTAGE - 1; i >= 0; i--) begin
        if (ents[i].valid && ents[i].regwrite &&
            (ents[i].rd == MAX_RW'(rs))) begin
          sel    = SW'(i + 1);
          hazard = ents[i].memread && (i < LOAD_LAT);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks destination registers of in-flight instructions and
//            produces forwarding selects, load-use stalls and branch flushes
//            for the decode stage.
// Ports    : clk, rst (async, active low)
//            id_valid/id_rs/id_rs_used/id_rd/id_regwrite/id_memread - decode
//            br_taken  - branch resolved taken in entry FLUSH_STAGE-1
//            ext_stall - memory wait, freezes everything
//            stall/flush/fwd_sel - combinational pipeline controls
//            stall_cnt/flush_cnt - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter  int NREG        = 32,
  parameter  int NSTAGE      = 3,
  parameter  int NSRC        = 2,
  parameter  int LOAD_LAT    = 1,
  parameter  int FLUSH_STAGE = 1,
  localparam int RW          = reg_addr_width(NREG),
  localparam int SW          = fwd_sel_width(NSTAGE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [NSRC*RW-1:0] id_rs,
  input  logic [NSRC-1:0]    id_rs_used,
  input  logic [RW-1:0]      id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               br_taken,
  input  logic               ext_stall,
  output logic               stall,
  output logic               flush,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  entry_t          ents [NSTAGE];
  logic [NSRC-1:0] src_hazard;
  logic            hazard;
  logic            admit;
  entry_t          id_entry;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_match #(
      .NSTAGE   (NSTAGE),
      .RW       (RW),
      .SW       (SW),
      .LOAD_LAT (LOAD_LAT)
    ) u_match (
      .rs      (id_rs[k*RW +: RW]),
      .rs_used (id_rs_used[k]),
      .ents    (ents),
      .sel     (fwd_sel[k*SW +: SW]),
      .hazard  (src_hazard[k])
    );
  end

  assign hazard = |src_hazard;
  // A frozen pipeline cannot resolve a branch, so br_taken is ignored then.
  assign flush  = br_taken & ~ext_stall;
  // Flush wins over a load-use stall: the stalled instruction is squashed.
  assign stall  = ext_stall | (hazard & ~flush);
  assign admit  = id_valid & ~hazard & ~flush;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = 1'b1;
    id_entry.rd       = MAX_RW'(id_rd);
    id_entry.regwrite = id_regwrite;
    id_entry.memread  = id_memread;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSTAGE; i++) begin
        ents[i] <= '0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!ext_stall) begin
      for (int i = NSTAGE - 1; i > 0; i--) begin
        ents[i] <= ents[i-1];
      end
      ents[0] <= admit ? id_entry : '0;
      // Entry 0 already gets a bubble via admit; squash the rest of the
      // younger window after the shift.
      if (flush) begin
        for (int i = 1; (i < FLUSH_STAGE) && (i < NSTAGE); i++) begin
          ents[i] <= '0;
        end
      end
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed scoreboard bench for hazard_scoreboard (default
//            parameters). Stimulus pushes hand-computed expectations; a
//            monitor pops and compares them at the falling edge, or
//            immediately when the stimulus raises an asynchronous check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int RW = 5;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [9:0]    id_rs;
  logic [1:0]    id_rs_used;
  logic [RW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_memread;
  logic          br_taken;
  logic          ext_stall;
  logic          stall;
  logic          flush;
  logic [3:0]    fwd_sel;
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .br_taken    (br_taken),
    .ext_stall   (ext_stall),
    .stall       (stall),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic [1:0]  fwd0;
    logic [1:0]  fwd1;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q [$];
  int   checks = 0;
  int   errors = 0;
  event chk_now;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, req);
    end
  endtask

  // Monitor: consumes every pending expectation when outputs are stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "stall",     {31'd0, stall},          {31'd0, e.stall});
        cmp(e.name, "flush",     {31'd0, flush},          {31'd0, e.flush});
        cmp(e.name, "fwd_sel0",  {30'd0, fwd_sel[1:0]},   {30'd0, e.fwd0});
        cmp(e.name, "fwd_sel1",  {30'd0, fwd_sel[3:2]},   {30'd0, e.fwd1});
        cmp(e.name, "stall_cnt", stall_cnt,               e.sc);
        cmp(e.name, "flush_cnt", flush_cnt,               e.fc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] rs0,
                       input logic [RW-1:0] rs1, input logic [1:0] used,
                       input logic [RW-1:0] rd, input logic rw,
                       input logic mr, input logic br, input logic es);
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rs_used  = used;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    br_taken    = br;
    ext_stall   = es;
  endtask

  task automatic expect_out(input string name, input logic st, input logic fl,
                            input logic [1:0] f0, input logic [1:0] f1,
                            input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.name = name; e.stall = st; e.flush = fl;
    e.fwd0 = f0; e.fwd1 = f1; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive(1, 5'd0, 5'd0, 2'b00, 5'd1, 1, 0, 0, 0);
    tick; tick;
    expect_out("reset_idle", 0, 0, 0, 0, 0, 0);
    tick;
    rst = 1'b1;

    // Load-use: load x5 enters entry 0, next instruction reads x5.
    drive(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 1, 0, 0);
    expect_out("lu_issue", 0, 0, 0, 0, 0, 0);
    tick;
    drive(1, 5'd5, 5'd0, 2'b01, 5'd6, 1, 0, 0, 0);
    expect_out("lu_stall", 1, 0, 1, 0, 0, 0);
    tick;
    expect_out("lu_fwd", 0, 0, 2, 0, 1, 0);
    tick;   // e0=x6, e1=bubble, e2=ld x5

    // ALU chain: x3 lands in entries 0 and 1.
    drive(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 0, 0, 0);
    expect_out("alu_a", 0, 0, 0, 0, 1, 0);
    tick;   // e0=x3, e1=x6, e2=bubble
    drive(1, 5'd6, 5'd3, 2'b11, 5'd3, 1, 0, 0, 0);
    expect_out("alu_b", 0, 0, 2, 1, 1, 0);
    tick;   // e0=x3, e1=x3, e2=x6
    drive(1, 5'd3, 5'd6, 2'b11, 5'd0, 0, 0, 0, 0);
    expect_out("alu_youngest", 0, 0, 1, 3, 1, 0);
    tick;   // e0=nowrite, e1=x3, e2=x3

    // x0: load writing x0, then reads of x0 and an unused x3 source.
    drive(1, 5'd0, 5'd0, 2'b00, 5'd0, 1, 1, 0, 0);
    expect_out("x0_issue", 0, 0, 0, 0, 1, 0);
    tick;   // e0=ld x0, e1=nowrite, e2=x3
    drive(1, 5'd0, 5'd3, 2'b01, 5'd7, 1, 0, 0, 0);
    expect_out("x0_and_unused", 0, 0, 0, 0, 1, 0);
    tick;   // e0=x7, e1=ld x0, e2=nowrite

    // Flush versus load-use stall.
    drive(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 1, 0, 0);
    expect_out("fl_load", 0, 0, 0, 0, 1, 0);
    tick;   // e0=ld x9, e1=x7, e2=ld x0
    drive(1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 0, 1, 0);
    expect_out("fl_vs_stall", 0, 1, 1, 0, 1, 0);
    tick;   // e0=bubble, e1=ld x9, e2=x7
    drive(1, 5'd9, 5'd10, 2'b11, 5'd10, 1, 0, 0, 0);
    expect_out("fl_after", 0, 0, 2, 0, 1, 1);
    tick;   // e0=x10, e1=bubble, e2=ld x9

    // ext_stall for three cycles with br_taken pulsing.
    drive(1, 5'd10, 5'd0, 2'b01, 5'd11, 1, 1, 1, 1);
    expect_out("es_0", 1, 0, 1, 0, 1, 1);
    tick;
    drive(1, 5'd10, 5'd0, 2'b01, 5'd11, 1, 1, 0, 1);
    expect_out("es_1", 1, 0, 1, 0, 1, 1);
    tick;
    drive(1, 5'd10, 5'd0, 2'b01, 5'd11, 1, 1, 1, 1);
    expect_out("es_2", 1, 0, 1, 0, 1, 1);
    tick;
    drive(1, 5'd10, 5'd9, 2'b11, 5'd12, 0, 0, 0, 0);
    expect_out("es_release", 0, 0, 1, 3, 1, 1);
    tick;   // e0=nowrite, e1=x10, e2=bubble

    // Fill all entries, then reset asynchronously.
    drive(1, 5'd0, 5'd0, 2'b00, 5'd13, 1, 0, 0, 0);
    expect_out("rs_fill0", 0, 0, 0, 0, 1, 1);
    tick;   // e0=x13, e1=nowrite, e2=x10
    drive(1, 5'd13, 5'd10, 2'b11, 5'd14, 1, 0, 0, 0);
    expect_out("rs_fill1", 0, 0, 1, 3, 1, 1);
    tick;   // e0=x14, e1=x13, e2=nowrite
    drive(1, 5'd14, 5'd13, 2'b11, 5'd15, 1, 0, 0, 0);
    expect_out("rs_full", 0, 0, 1, 2, 1, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    expect_out("rs_async", 0, 0, 0, 0, 0, 0);
    -> chk_now;
    tick;
    expect_out("rs_next", 0, 0, 0, 0, 0, 0);
    tick;
    rst = 1'b1;
    expect_out("rs_release", 0, 0, 0, 0, 0, 0);
    tick;
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
